// File: rtl/hitor_tot_pkg.sv
// Shared field layout, limits and FSM encoding for the HITOR time-over-threshold source.
// Word layout: [31:28] id, [27] type (1 = timestamp extension), [26:0] payload.
package hitor_tot_pkg;

  localparam int TOT_W      = 12;
  localparam int TS_LO_W    = 15;
  localparam int EXT_W      = 27;
  localparam int EXT_TS_LSB = 15;

  localparam int ID_MSB   = 31;
  localparam int ID_LSB   = 28;
  localparam int TYPE_BIT = 27;
  localparam int TOT_MSB  = 26;
  localparam int TOT_LSB  = 15;
  localparam int TS_MSB   = 14;
  localparam int TS_LSB   = 0;
  localparam int EXT_MSB  = 26;
  localparam int EXT_LSB  = 0;

  localparam logic [TOT_W-1:0] TOT_MAX = 12'd4095;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic logic [31:0] pack_word(input logic [3:0]       id,
                                            input logic             is_ext,
                                            input logic [EXT_W-1:0] payload);
    logic [31:0] w;
    w                 = '0;
    w[ID_MSB:ID_LSB]  = id;
    w[TYPE_BIT]       = is_ext;
    w[EXT_MSB:EXT_LSB] = payload;
    return w;
  endfunction

endpackage

// File: rtl/tot_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The writer guarantees space before
// asserting i_wr; o_free lets it make that decision.
module tot_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop     = i_rd && (r_count != '0);
  assign o_empty   = (r_count == '0);
  assign o_free    = (AW+1)'(DEPTH) - r_count;
  // Mask the head while empty so stale storage never leaks onto the bus.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hitor_tot_fifo.sv
// HITOR time-over-threshold source: synchronises DI, measures each accepted pulse and
// buffers ToT words in a FWFT FIFO. Define HITOR_TOT_TS_EXT_EN to also emit a timestamp extension word.
module hitor_tot_fifo
  import hitor_tot_pkg::*;
#(
  parameter logic [3:0] IDENTIFIER = 4'b1000,
  parameter int         DEPTH      = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        DI,
  input  logic [63:0] TIMESTAMP,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic [7:0]  LOST_CNT
);

  localparam int AW = $clog2(DEPTH);
`ifdef HITOR_TOT_TS_EXT_EN
  localparam logic [AW:0] NEED = (AW+1)'(2);
`else
  localparam logic [AW:0] NEED = (AW+1)'(1);
`endif

  logic               r_di_meta;
  logic               r_di_s;
  logic               r_di_d;
  logic               w_rise;
  logic               w_fall;
  state_t             r_state;
  state_t             w_state_next;
  logic               w_has_room;
  logic               w_accept;
  logic               w_drop;
  logic               w_wr_tot;
  logic               w_wr_en;
  logic [31:0]        w_wr_data;
  logic [31:0]        w_tot_word;
  logic [AW:0]        w_free;
  logic [TOT_W-1:0]   r_tot;
  logic [TS_LO_W-1:0] r_ts_lat;
  logic [7:0]         r_lost_cnt;
  logic               w_unused_ts;

  // Sync chain resets high so a line already asserted at reset release is not counted.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_di_meta <= 1'b1;
      r_di_s    <= 1'b1;
      r_di_d    <= 1'b1;
    end else begin
      r_di_meta <= DI;
      r_di_s    <= r_di_meta;
      r_di_d    <= r_di_s;
    end
  end

  assign w_rise     = r_di_s & ~r_di_d;
  assign w_fall     = ~r_di_s & r_di_d;
  assign w_has_room = (w_free >= NEED);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rise && EN) begin
          w_state_next = w_has_room ? ST_HIGH : ST_DROP;
        end
      end
      ST_HIGH, ST_DROP: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_drop   = 1'b0;
    w_wr_tot = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = w_rise && EN && w_has_room;
        w_drop   = w_rise && EN && !w_has_room;
      end
      ST_HIGH: w_wr_tot = w_fall;
      default: ;
    endcase
  end

  // The rising-edge cycle itself is the first counted high cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tot      <= '0;
      r_ts_lat   <= '0;
      r_lost_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tot    <= TOT_W'(1);
        r_ts_lat <= TIMESTAMP[TS_LO_W-1:0];
      end else if ((r_state == ST_HIGH) && r_di_s && (r_tot != TOT_MAX)) begin
        r_tot <= r_tot + 1'b1;
      end
      if (w_drop && (r_lost_cnt != 8'hFF)) begin
        r_lost_cnt <= r_lost_cnt + 1'b1;
      end
    end
  end

  assign w_tot_word  = pack_word(IDENTIFIER, 1'b0, {r_tot, r_ts_lat});
  assign w_unused_ts = ^TIMESTAMP;

`ifdef HITOR_TOT_TS_EXT_EN
  // Extension and ToT writes fall in different FSM states, so one write port suffices.
  assign w_wr_en   = w_wr_tot | w_accept;
  assign w_wr_data = w_wr_tot ? w_tot_word
                              : pack_word(IDENTIFIER, 1'b1,
                                          TIMESTAMP[EXT_TS_LSB+EXT_W-1:EXT_TS_LSB]);
`else
  assign w_wr_en   = w_wr_tot;
  assign w_wr_data = w_tot_word;
`endif

  tot_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_wr      (w_wr_en),
    .i_wr_data (w_wr_data),
    .i_rd      (FIFO_READ),
    .o_rd_data (FIFO_DATA),
    .o_empty   (FIFO_EMPTY),
    .o_free    (w_free)
  );

  assign LOST_CNT = r_lost_cnt;

endmodule

// File: tb/tb_hitor_tot_fifo.sv
// Directed bench for hitor_tot_fifo: reset, single pulse, saturation, gating, overflow,
// back-to-back with continuous reads, reset mid-pulse; extension build has its own sequence.
module tb_hitor_tot_fifo;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        en        = 1'b1;
  logic        di        = 1'b0;
  logic [63:0] ts        = '0;
  logic        fifo_read = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic [7:0]  lost_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] mon_q [$];

  always #5 clk = ~clk;

  hitor_tot_fifo #(
    .IDENTIFIER (4'b1000),
    .DEPTH      (16)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .EN         (en),
    .DI         (di),
    .TIMESTAMP  (ts),
    .FIFO_READ  (fifo_read),
    .FIFO_EMPTY (fifo_empty),
    .FIFO_DATA  (fifo_data),
    .LOST_CNT   (lost_cnt)
  );

  always @(negedge clk) begin
    if (mon_en && fifo_read && !fifo_empty) begin
      mon_q.push_back(fifo_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising clock edge; di_s is then high for 'high' cycles, low for 'low'.
  task automatic pulse(input int high, input int low, input logic [63:0] stamp);
    ts = stamp;
    di = 1'b1;
    repeat (high) @(posedge clk);
    #1 di = 1'b0;
    repeat (low) @(posedge clk);
    #1;
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    @(negedge clk);
    check({tag, "_nonempty"}, 32'(fifo_empty), 32'd0);
    check(tag, fifo_data, exp);
    fifo_read = 1'b1;
    @(posedge clk);
    #1 fifo_read = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    do_reset();
    @(negedge clk);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_data", fifo_data, 32'h0);
    check("rst_lost", 32'(lost_cnt), 32'd0);

`ifdef HITOR_TOT_TS_EXT_EN
    sync_edge();
    pulse(5, 4, 64'h0000_0123_4567_8000);
    pop("ext_word", 32'h8A46_8ACF);
    pop("ext_tot", 32'h8002_8000);
    for (int i = 0; i < 8; i++) begin
      pulse(2, 2, 64'(i));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ext_fill_lost", 32'(lost_cnt), 32'd0);
    pop("ext_fill_head", 32'h8800_0000);
    pulse(2, 4, 64'h9);
    @(negedge clk);
    check("ext_drop_lost", 32'(lost_cnt), 32'd1);
`else
    // Single pulse: empty must still be high in the fall-detect cycle, low one cycle later.
    sync_edge();
    ts = 64'h1234;
    di = 1'b1;
    repeat (10) @(posedge clk);
    #1 di = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_empty_at_fall", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    check("t1_empty_after", 32'(fifo_empty), 32'd0);
    pop("t1_word", 32'h8005_1234);
    @(negedge clk);
    check("t1_empty_popped", 32'(fifo_empty), 32'd1);

    sync_edge();
    pulse(5000, 4, 64'h777);
    pop("t2_sat_word", 32'h87FF_8777);
    @(negedge clk);
    check("t2_one_word", 32'(fifo_empty), 32'd1);

    sync_edge();
    en = 1'b0;
    pulse(6, 4, 64'h99);
    en = 1'b1;
    @(negedge clk);
    check("t3_gated_empty", 32'(fifo_empty), 32'd1);
    check("t3_gated_lost", 32'(lost_cnt), 32'd0);

    sync_edge();
    for (int i = 0; i < 20; i++) begin
      pulse(2, 2, 64'(i));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_lost", 32'(lost_cnt), 32'd4);
    pop("t4_w0", 32'h8001_0000);
    pulse(2, 4, 64'h55);
    @(negedge clk);
    check("t4_lost_after", 32'(lost_cnt), 32'd4);
    for (int i = 1; i < 16; i++) begin
      pop($sformatf("t4_w%0d", i), 32'h8001_0000 | 32'(i));
    end
    pop("t4_new", 32'h8001_0055);
    @(negedge clk);
    check("t4_drained", 32'(fifo_empty), 32'd1);

    sync_edge();
    mon_q.delete();
    mon_en    = 1'b1;
    fifo_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse(3, 1, 64'h100 + 64'(i));
    end
    repeat (6) @(posedge clk);
    #1 fifo_read = 1'b0;
    mon_en = 1'b0;
    check("t5_count", 32'(mon_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      got = (i < mon_q.size()) ? mon_q[i] : 32'hDEAD_DEAD;
      check($sformatf("t5_w%0d", i), got, 32'h8001_8100 + 32'(i));
    end
    @(negedge clk);
    check("t5_lost", 32'(lost_cnt), 32'd4);
    check("t5_empty", 32'(fifo_empty), 32'd1);

    sync_edge();
    pulse(2, 2, 64'h1);
    pulse(2, 2, 64'h2);
    pulse(2, 4, 64'h3);
    @(negedge clk);
    check("t6_buffered", 32'(fifo_empty), 32'd0);
    sync_edge();
    di = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 di = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t6_empty", 32'(fifo_empty), 32'd1);
    check("t6_lost", 32'(lost_cnt), 32'd0);
    check("t6_data", fifo_data, 32'h0);
    sync_edge();
    pulse(4, 4, 64'h42);
    pop("t6_recover", 32'h8002_0042);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hitor_tot_fifo.md
# hitor_tot_fifo

Upstream data source for the `rrp_arbiter` that measures time-over-threshold (ToT) of a HITOR discriminator line. It timestamps each accepted leading edge from the shared 64-bit `TIMESTAMP` bus and buffers the resulting 32-bit words in an internal FWFT FIFO. It presents the standard `FIFO_READ`/`FIFO_EMPTY`/`FIFO_DATA` source interface, so it plugs directly into one arbiter request slot alongside the `timestamp640` sources.

## Interface
- `IDENTIFIER`, default 4'b1000: written into word bits [31:28].
- `DEPTH`, default 16: FIFO depth in words; must be a power of 2, minimum 4.
- `CLK` input 1: single clock for all logic.
- `RST_N` input 1: reset, synchronous, active-low.
- `EN` input 1: gate for accepting new leading edges (e.g. `GATE_TDC`).
- `DI` input 1: asynchronous HITOR line.
- `TIMESTAMP` input 64: free-running timestamp, synchronous to `CLK`.
- `FIFO_READ` input 1: pop request from the arbiter.
- `FIFO_EMPTY` output 1: high when no word is available.
- `FIFO_DATA` output 32: head word; valid while `FIFO_EMPTY`=0.
- `LOST_CNT` output 8: saturating count of dropped pulses.

## Operation
- **Input synchronisation:** `DI` passes through 2 FFs to give `di_s`, then 1 further FF to give `di_d`.
  - Rising edge: `di_s`=1 and `di_d`=0.
  - Falling edge: `di_s`=0 and `di_d`=1.
- **FSM states:** IDLE, HIGH, DROP.
- **IDLE:** on a rising edge with `EN`=1, make the accept decision:
  - Accept if free entries ≥ `NEED` → go to HIGH, latch `ts_lat`=`TIMESTAMP`, set `tot`=1.
  - Otherwise → go to DROP and increment `LOST_CNT`.
  - A rising edge with `EN`=0 is ignored and the FSM stays in IDLE.
- **HIGH:** `tot` increments by 1 per cycle while `di_s`=1, saturating at 4095.
  - On a falling edge, write the ToT word and return to IDLE.
  - The `EN` level is irrelevant once in HIGH.
- **DROP:** on a falling edge → IDLE. Nothing is written.
- **ToT word:**
  - [31:28] `IDENTIFIER`
  - [27] = 0
  - [26:15] = `tot`: cycles with `di_s` high, 1..4095
  - [14:0] = `ts_lat`[14:0]
- **FIFO behaviour:**
  - FWFT: `FIFO_DATA` shows the head word.
  - `FIFO_READ`=1 with `FIFO_EMPTY`=0 pops in that cycle.
  - `FIFO_READ` while empty is ignored.
  - A write and a pop in the same cycle are both performed.
  - Space is reserved at the accept decision, so a write can never overflow.
- **`LOST_CNT`:** saturates at 255; cleared only by reset.

## Timing
- Edge latency: a `DI` transition is seen as an edge 3 `CLK` edges after it is sampled.
- `TIMESTAMP` is latched in the rising-edge detection cycle.
- The ToT word is written in the falling-edge detection cycle. `FIFO_EMPTY` falls on the next cycle.
- IDLE is re-entered in the cycle after the falling edge, so a new rising edge can be accepted from then on. Minimum `di_s` low time between counted pulses: 1 cycle.
- A 1-cycle `di_s` pulse gives ToT=1.
- Reset values:
  - State IDLE, FIFO empty.
  - `FIFO_EMPTY`=1, `FIFO_DATA`=0, `LOST_CNT`=0, `tot`=0.
  - Sync FFs `di_s`/`di_d` reset to 1, so a pulse already high at reset release is not counted.
- Reset mid-pulse: the pulse is abandoned and all buffered words are discarded.

## Configuration
- Macro: `HITOR_TOT_TS_EXT_EN`.
- **Defined:**
  - `NEED`=2.
  - On accept, an extension word is written in the accept cycle: [31:28] `IDENTIFIER`, [27]=1, [26:0]=`TIMESTAMP`[41:15].
  - The ToT word follows at the falling edge.
  - The extension word always precedes its ToT word.
- **Undefined:**
  - `NEED`=1.
  - Only ToT words are produced.
  - Bit [27] is always 0.

## Structure
- Package `hitor_tot_pkg` holds:
  - Field position constants: ID, TYPE, TOT, TS and EXT.
  - `TOT_W`=12, `TS_LO_W`=15, `TOT_MAX`=4095.
  - FSM state enum.
- Sub-module `tot_sync_fifo`: synchronous FWFT FIFO with `DEPTH` and width parameters.
  - Outputs: `FREE` count, `EMPTY`.
  - Write is asserted only after the top level has checked space.
- Top level: synchroniser, edge detect, FSM, ToT counter, `LOST_CNT`.

## Test plan
- **Single pulse:** `EN`=1, `TIMESTAMP`=0x1234 at the rising edge, `di_s` high 10 cycles → one word 0x8000_0000 | (10<<15) | 0x1234; `FIFO_EMPTY` falls 1 cycle after the falling edge.
- **Saturation and gating:**
  - 5000-cycle pulse → ToT field 4095, exactly one word.
  - Pulse starting with `EN`=0 → no word, `LOST_CNT` unchanged.
- **Overflow:** `DEPTH`=16, no reads, 20 pulses → 16 words, `LOST_CNT`=4. Pop 1 word, send 1 pulse → accepted.
- **Back-to-back:** pulses of 3 cycles high, 1 cycle low, ×8, with continuous `FIFO_READ` → 8 words, all ToT=3, in order, none lost.
- **Reset mid-pulse:** `RST_N`=0 for 1 cycle while in HIGH with 3 words buffered → `FIFO_EMPTY`=1, `LOST_CNT`=0, and no word is produced for the pulse in progress.
- **With `HITOR_TOT_TS_EXT_EN`:**
  - `TIMESTAMP`=0x0000_0123_4567_8000 → ext word, then ToT word.
  - With 1 free entry → pulse dropped, `LOST_CNT`+1.
